// File: rtl/clk_div_detect_pkg.sv
`default_nettype none
// ============================================================================
// clk_div_detect_pkg
// Shared state encoding, counter limits and tolerance helper for the detector.
// Revision: 1.0
// ============================================================================
package clk_div_detect_pkg;

  localparam int         CNT_W   = 9;
  localparam logic [8:0] CNT_MAX = 9'd511;
  localparam logic [8:0] DIV_MAX = 9'd255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  // Signed 10-bit difference so an interval shorter than the reference never wraps.
  function automatic logic in_tol(input logic [8:0] c, input logic [7:0] r,
                                  input logic [9:0] tol);
    logic signed [9:0] diff;
    logic        [9:0] mag;
    diff = $signed({1'b0, c}) - $signed({2'b00, r});
    mag  = diff[9] ? 10'(-diff) : 10'(diff);
    return (mag <= tol);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_detect_edge_sync.sv
`default_nettype none
// ============================================================================
// edge_sync
// Two-flop synchroniser plus an edge flop; flags both rising and falling edges.
// Revision: 1.0
// ============================================================================
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic level,
  output logic edge_det
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_async;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level    = s2_q;
  assign edge_det = s2_q ^ s3_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_detect.sv
`default_nettype none
// ============================================================================
// clk_div_detect
// Measures half-periods of an async square wave and recovers the divisor.
// Revision: 1.0
// ============================================================================
module clk_div_detect
  import clk_div_detect_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOL        = 1,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sig_in,
  output logic [7:0] divisor,
  output logic       locked,
  output logic [8:0] interval,
  output logic       interval_valid
);

  localparam logic [4:0] LOCK_N = 5'(LOCK_COUNT);
  localparam logic [4:0] MISS_N = 5'(MISS_LIMIT);
  localparam logic [9:0] TOL_V  = 10'(TOL);

  logic sig_edge;

  edge_sync u_edge_sync (
    .clk      (clk),
    .reset    (reset),
    .d_async  (sig_in),
    .level    (),
    .edge_det (sig_edge)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       ref_q, ref_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic [7:0]       divisor_q, divisor_d;
  logic             locked_q, locked_d;
  logic [8:0]       interval_q, interval_d;
  logic             ival_q, ival_d;

  logic       fits, is_match, restart;
  logic [4:0] match_next, miss_next;

  assign fits       = (cnt_q <= DIV_MAX);
  assign is_match   = fits && in_tol(cnt_q, ref_q, TOL_V);
  assign match_next = {1'b0, match_cnt_q} + 5'd1;
  assign miss_next  = {1'b0, miss_cnt_q} + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ref_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      divisor_q   <= '0;
      locked_q    <= 1'b0;
      interval_q  <= '0;
      ival_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_q       <= ref_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      divisor_q   <= divisor_d;
      locked_q    <= locked_d;
      interval_q  <= interval_d;
      ival_q      <= ival_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    divisor_d   = divisor_q;
    locked_d    = locked_q;
    interval_d  = interval_q;
    ival_d      = 1'b0;
    restart     = 1'b0;

    if (sig_edge)
      cnt_d = '0;
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 9'd1;

    if (sig_edge) begin
      if (state_q != ST_IDLE) begin
        interval_d = cnt_q;
        ival_d     = 1'b1;
      end
      case (state_q)
        ST_IDLE:    state_d = ST_MEASURE;
        ST_MEASURE: restart = fits;
        ST_CONFIRM: begin
          if (is_match) begin
            match_cnt_d = match_next[3:0];
            if (match_next >= LOCK_N) begin
              divisor_d  = ref_q;
              locked_d   = 1'b1;
              miss_cnt_d = '0;
              state_d    = ST_LOCKED;
            end
          end else if (fits) begin
            restart = 1'b1;
          end else begin
            state_d = ST_MEASURE;
          end
        end
        ST_LOCKED: begin
          if (is_match) begin
            miss_cnt_d = '0;
          end else begin
            miss_cnt_d = miss_next[3:0];
            if (miss_next >= MISS_N) begin
              locked_d = 1'b0;
              if (fits)
                restart = 1'b1;
              else
                state_d = ST_MEASURE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (cnt_d == CNT_MAX)) begin
      // Carrier stopped: drop lock but keep the last divisor for reuse.
      state_d  = ST_IDLE;
      locked_d = 1'b0;
    end

    // A fresh reference counts as the first matching interval.
    if (restart) begin
      ref_d       = cnt_q[7:0];
      match_cnt_d = 4'd1;
      if (LOCK_N <= 5'd1) begin
        divisor_d  = cnt_q[7:0];
        locked_d   = 1'b1;
        miss_cnt_d = '0;
        state_d    = ST_LOCKED;
      end else begin
        state_d = ST_CONFIRM;
      end
    end
  end

  assign divisor        = divisor_q;
  assign locked         = locked_q;
  assign interval       = interval_q;
  assign interval_valid = ival_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_detect.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_clk_div_detect
// Directed stimulus with an interval scoreboard for clk_div_detect.
// Revision: 1.0
// ============================================================================
module tb_clk_div_detect;

  logic       clk = 1'b0;
  logic       reset;
  logic       sig_in;
  logic [7:0] divisor;
  logic       locked;
  logic [8:0] interval;
  logic       interval_valid;

  int         n_vec  = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  clk_div_detect dut (
    .clk            (clk),
    .reset          (reset),
    .sig_in         (sig_in),
    .divisor        (divisor),
    .locked         (locked),
    .interval       (interval),
    .interval_valid (interval_valid)
  );

  // Scoreboard: every reported interval must match the oldest expected one.
  always @(negedge clk) begin
    if (interval_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL unexpected_interval: observed %0d expected none", interval);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        assert (interval === e) else begin
          n_fail++;
          $error("FAIL interval_sb: observed %0d expected %0d", interval, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tog(input int exp_iv);
    if (exp_iv >= 0) exp_q.push_back(9'(exp_iv));
    sig_in = ~sig_in;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic reset_dut();
    reset  = 1'b1;
    sig_in = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);
  endtask

  // Toggle every 96 cycles from IDLE; lock lands one cycle after the 5th edge.
  task automatic lock95();
    tog(-1);
    cyc(96);
    repeat (3) begin
      tog(95);
      cyc(96);
    end
    tog(95);
    cyc(2);
    chk("pre_lock", {8'd0, locked}, 9'd0);
    cyc(1);
    chk("lock95", {8'd0, locked}, 9'd1);
    chk("div95", {1'b0, divisor}, 9'd95);
    cyc(93);
  endtask

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    cyc(3);
    chk("rst_divisor", {1'b0, divisor}, 9'd0);
    chk("rst_locked", {8'd0, locked}, 9'd0);
    chk("rst_interval", interval, 9'd0);
    chk("rst_ival", {8'd0, interval_valid}, 9'd0);
    reset = 1'b0;
    cyc(2);

    lock95();
    chk("interval95", interval, 9'd95);

    // Single long half-period while locked is tolerated.
    tog(95); cyc(98);
    tog(97); cyc(96);
    tog(95); cyc(96);
    chk("one_miss_locked", {8'd0, locked}, 9'd1);
    chk("one_miss_div", {1'b0, divisor}, 9'd95);

    // Two in a row drop lock, then three more matches relock at 97.
    tog(95); cyc(98);
    tog(97); cyc(98);
    tog(97); cyc(3);
    chk("two_miss_unlock", {8'd0, locked}, 9'd0);
    chk("two_miss_div", {1'b0, divisor}, 9'd95);
    cyc(95);
    tog(97); cyc(98);
    tog(97); cyc(98);
    tog(97); cyc(3);
    chk("relock97", {8'd0, locked}, 9'd1);
    chk("div97", {1'b0, divisor}, 9'd97);

    // Stopped carrier: lock holds through cnt=510, drops exactly at 511.
    cyc(510);
    chk("timeout_pre", {8'd0, locked}, 9'd1);
    cyc(1);
    chk("timeout_unlock", {8'd0, locked}, 9'd0);
    chk("timeout_div_held", {1'b0, divisor}, 9'd97);

    // Divisor 0: toggle every clk cycle, starting from IDLE.
    tog(-1); cyc(1);
    repeat (6) begin
      tog(0);
      cyc(1);
    end
    cyc(3);
    chk("lock_d0", {8'd0, locked}, 9'd1);
    chk("div_d0", {1'b0, divisor}, 9'd0);

    // Divisor 255: the largest interval still accepted.
    reset_dut();
    tog(-1); cyc(256);
    repeat (4) begin
      tog(255);
      cyc(256);
    end
    chk("lock_d255", {8'd0, locked}, 9'd1);
    chk("div_d255", {1'b0, divisor}, 9'd255);
    cyc(520);
    chk("d255_timeout", {8'd0, locked}, 9'd0);

    // Alternating 40/60 never settles.
    tog(-1); cyc(41);
    repeat (4) begin
      tog(40); cyc(61);
      tog(60); cyc(41);
    end
    chk("alt_no_lock", {8'd0, locked}, 9'd0);
    chk("alt_last_iv", interval, 9'd60);
    chk("alt_div_held", {1'b0, divisor}, 9'd255);

    // Asynchronous reset in CONFIRM clears outputs without a clock edge.
    reset  = 1'b1;
    sig_in = 1'b0;
    #1;
    chk("arst_divisor", {1'b0, divisor}, 9'd0);
    chk("arst_interval", interval, 9'd0);
    chk("arst_locked", {8'd0, locked}, 9'd0);
    chk("arst_ival", {8'd0, interval_valid}, 9'd0);
    cyc(2);
    reset = 1'b0;
    cyc(2);
    lock95();

    cyc(5);
    chk("sb_drained", 9'(exp_q.size()), 9'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
